// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAG  = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic [7:0] TAG_BASE_DEFAULT = 8'hA0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, cyclically.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IW'((32'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        idx_o        = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources; each grant sends
// a channel tag byte followed by up to MAX_BURST data bytes.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned MAX_BURST     = 16,
  parameter logic [7:0]  TAG_BASE      = TAG_BASE_DEFAULT,
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   uart_tx_free,
  output logic                   uart_transmit,
  output logic [7:0]             uart_tx_byte,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned BW = $clog2(MAX_BURST) + 1;
  localparam int unsigned SW = $clog2(STALL_TIMEOUT);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_TIMEOUT - 1);

  arb_state_e         state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IW-1:0]      gidx_q;
  logic [IW-1:0]      rr_ptr_q;
  logic [IW-1:0]      rr_ptr_d;
  logic               hold_q;
  logic [BW-1:0]      burst_cnt_q;
  logic [SW-1:0]      stall_cnt_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;
  logic               send_ok;
  logic               strobe_tag;
  logic               strobe_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  // hold_q covers the cycle before the UART has had a chance to drop tx_free.
  always_comb begin
    send_ok       = uart_tx_free && !hold_q;
    strobe_tag    = (state_q == TAG) && send_ok;
    strobe_data   = (state_q == DATA) && send_ok && sel_valid;
    uart_transmit = strobe_tag || strobe_data;
    uart_tx_byte  = '0;
    if (strobe_tag) begin
      uart_tx_byte = TAG_BASE + 8'(gidx_q);
    end else if (strobe_data) begin
      uart_tx_byte = sel_data;
    end
    req_ready = strobe_data ? grant_q : '0;
    grant     = grant_q;
    busy      = (state_q != IDLE);
    rr_ptr_d  = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      hold_q      <= 1'b0;
      burst_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      hold_q <= uart_transmit;
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            grant_q     <= arb_gnt;
            gidx_q      <= arb_idx;
            burst_cnt_q <= '0;
            stall_cnt_q <= '0;
            state_q     <= TAG;
          end
        end
        TAG: begin
          if (send_ok) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          if (strobe_data) begin
            burst_cnt_q <= burst_cnt_q + 1'b1;
            stall_cnt_q <= '0;
            if (sel_last || burst_cnt_q == BURST_LAST) begin
              state_q  <= IDLE;
              grant_q  <= '0;
              rr_ptr_q <= rr_ptr_d;
            end
          end else if (!sel_valid) begin
            if (stall_cnt_q == STALL_LAST) begin
              state_q  <= IDLE;
              grant_q  <= '0;
              rr_ptr_q <= rr_ptr_d;
            end else begin
              stall_cnt_q <= stall_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple frame-timed UART model.
module tb_uart_tx_arbiter;

  localparam int FRAME = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        uart_tx_free;
  logic        uart_transmit;
  logic [7:0]  uart_tx_byte;
  logic [3:0]  grant;
  logic        busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ       (4),
    .MAX_BURST     (16),
    .TAG_BASE      (8'hA0),
    .STALL_TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .uart_tx_free  (uart_tx_free),
    .uart_transmit (uart_transmit),
    .uart_tx_byte  (uart_tx_byte),
    .grant         (grant),
    .busy          (busy)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] mem   [4][32];
  logic       lastf [4][32];
  int         len [4];
  int         pos [4];
  int         ubusy;
  logic       force_free;
  int         cycle;
  int         last_tx;
  int         adj;
  int         rdy2;
  logic [7:0] sb [$];
  int         sc [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (pos[i] < len[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = mem[i][pos[i]];
        req_last[i]        = lastf[i][pos[i]];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
    uart_tx_free = force_free || (ubusy == 0);
  endtask

  task automatic step();
    logic [3:0] rdy;
    logic       tx;
    @(negedge clk);
    rdy = req_ready;
    tx  = uart_transmit;
    if (tx) begin
      sb.push_back(uart_tx_byte);
      sc.push_back(cycle);
      if (last_tx == cycle - 1) adj++;
      last_tx = cycle;
    end
    if (rdy[2]) rdy2++;
    @(posedge clk);
    #1;
    cycle++;
    for (int i = 0; i < 4; i++) if (rdy[i]) pos[i]++;
    if (rst) ubusy = 0;
    else if (tx) ubusy = FRAME;
    else if (ubusy > 0) ubusy--;
    drive();
    #1;
  endtask

  function automatic logic [31:0] sbv(input int i);
    if (i < sb.size()) return {24'h0, sb[i]};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic wait_strobes(input string tag, input int n, input int bound);
    int k = 0;
    while (sb.size() < n && k < bound) begin
      step();
      k++;
    end
    check_eq(tag, sb.size(), n);
  endtask

  task automatic reset_all();
    rst        = 1'b1;
    force_free = 1'b0;
    ubusy      = 0;
    for (int i = 0; i < 4; i++) begin
      len[i] = 0;
      pos[i] = 0;
    end
    drive();
    step();
    step();
    rst = 1'b0;
    sb.delete();
    sc.delete();
    adj     = 0;
    rdy2    = 0;
    last_tx = -10;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [7:0] exp2 [10];
    int         gbad;
    int         k;

    cycle   = 0;
    last_tx = -10;
    req_valid = '0; req_data = '0; req_last = '0;

    // Reset state
    reset_all();
    check_eq("rst_grant", grant, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_transmit", {uart_transmit, uart_tx_byte}, 0);
    check_eq("rst_ready", req_ready, 0);

    // Single source, 3 bytes, 10-cycle UART frames
    reset_all();
    mem[0][0] = 8'h11; lastf[0][0] = 1'b0;
    mem[0][1] = 8'h22; lastf[0][1] = 1'b0;
    mem[0][2] = 8'h33; lastf[0][2] = 1'b1;
    len[0] = 3;
    drive();
    #1;
    check_eq("t1_idle_busy", busy, 0);
    step();
    check_eq("t1_grant_lat", grant, 4'b0001);
    check_eq("t1_tag_lat", {uart_transmit, uart_tx_byte}, 9'h1A0);
    gbad = 0;
    k = 0;
    while (sb.size() < 4 && k < 300) begin
      step();
      if (sb.size() < 4 && grant !== 4'b0001) gbad++;
      k++;
    end
    check_eq("t1_count", sb.size(), 4);
    check_eq("t1_b0", sbv(0), 32'hA0);
    check_eq("t1_b1", sbv(1), 32'h11);
    check_eq("t1_b2", sbv(2), 32'h22);
    check_eq("t1_b3", sbv(3), 32'h33);
    for (int i = 1; i < sc.size(); i++)
      check_eq($sformatf("t1_gap%0d", i), 32'((sc[i] - sc[i-1]) >= 10), 1);
    check_eq("t1_grant_held", gbad, 0);
    check_eq("t1_grant_after", grant, 0);
    check_eq("t1_busy_after", busy, 0);
    check_eq("t1_consumed", pos[0], 3);

    // All four sources pending: round-robin tag order
    reset_all();
    for (int i = 0; i < 4; i++) begin
      mem[i][0]   = 8'h40 + 8'(i);
      lastf[i][0] = 1'b1;
      len[i]      = 1;
    end
    mem[0][1] = 8'h50; lastf[0][1] = 1'b1; len[0] = 2;
    drive();
    #1;
    exp2 = '{8'hA0, 8'h40, 8'hA1, 8'h41, 8'hA2, 8'h42, 8'hA3, 8'h43, 8'hA0, 8'h50};
    wait_strobes("t2_count", 10, 800);
    for (int i = 0; i < 10; i++)
      check_eq($sformatf("t2_seq%0d", i), sbv(i), {24'h0, exp2[i]});

    // MAX_BURST split: 20 bytes, no last
    reset_all();
    for (int i = 0; i < 20; i++) begin
      mem[2][i]   = 8'h60 + 8'(i);
      lastf[2][i] = 1'b0;
    end
    len[2] = 20;
    drive();
    #1;
    wait_strobes("t3_count", 22, 1000);
    for (int i = 0; i < 20; i++) step();
    check_eq("t3_final_count", sb.size(), 22);
    check_eq("t3_tag0", sbv(0), 32'hA2);
    check_eq("t3_b15", sbv(16), 32'h6F);
    check_eq("t3_tag1", sbv(17), 32'hA2);
    check_eq("t3_b16", sbv(18), 32'h70);
    check_eq("t3_b19", sbv(21), 32'h73);
    check_eq("t3_ready_cnt", rdy2, 20);
    check_eq("t3_idle", busy, 0);

    // Stall timeout on source 1, source 3 waiting
    reset_all();
    mem[1][0] = 8'h81; lastf[1][0] = 1'b0;
    mem[1][1] = 8'h82; lastf[1][1] = 1'b0;
    len[1] = 2;
    mem[3][0] = 8'h93; lastf[3][0] = 1'b1;
    len[3] = 1;
    drive();
    #1;
    wait_strobes("t4_first", 3, 200);
    check_eq("t4_b0", sbv(0), 32'hA1);
    for (int i = 0; i < 7; i++) step();
    check_eq("t4_busy_pre", busy, 1);
    check_eq("t4_grant_pre", grant, 4'b0010);
    step();
    check_eq("t4_busy_close", busy, 0);
    check_eq("t4_grant_close", grant, 0);
    wait_strobes("t4_second", 5, 200);
    check_eq("t4_tag3", sbv(3), 32'hA3);
    check_eq("t4_b3", sbv(4), 32'h93);

    // Faulty UART: tx_free stuck high
    reset_all();
    force_free = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem[0][i]   = 8'hB0 + 8'(i);
      lastf[0][i] = (i == 2);
    end
    len[0] = 3;
    mem[1][0] = 8'hB8; lastf[1][0] = 1'b0;
    mem[1][1] = 8'hB9; lastf[1][1] = 1'b1;
    len[1] = 2;
    drive();
    #1;
    for (int i = 0; i < 60; i++) step();
    check_eq("t5_adjacent", adj, 0);
    check_eq("t5_count", sb.size(), 7);
    check_eq("t5_last", sbv(6), 32'hB9);

    // Reset mid-packet
    reset_all();
    mem[1][0] = 8'hD1; lastf[1][0] = 1'b1; len[1] = 1;
    drive();
    #1;
    wait_strobes("t6_pre", 2, 200);
    for (int i = 0; i < 5; i++) begin
      mem[2][i]   = 8'hE0 + 8'(i);
      lastf[2][i] = (i == 4);
    end
    len[2] = 5;
    mem[0][0] = 8'hC0; lastf[0][0] = 1'b1; len[0] = 1;
    drive();
    #1;
    wait_strobes("t6_mid", 4, 200);
    check_eq("t6_tag2", sbv(2), 32'hA2);
    check_eq("t6_grant_mid", grant, 4'b0100);
    rst = 1'b1;
    step();
    check_eq("t6_rst_grant", grant, 0);
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_ready", req_ready, 0);
    rst = 1'b0;
    step();
    check_eq("t6_regrant", grant, 4'b0001);
    check_eq("t6_retag", {uart_transmit, uart_tx_byte}, 9'h1A0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
